vga_sram_arbiter: RTL
=====================

# vga_sram_arbiter

Shares the single-port asynchronous pixel SRAM between the VGA scan-out path and a pixel-writer port. Scan-out reads have absolute priority whenever `video_on` is high. Writer requests are buffered in a small FIFO and drained during blanking, with one turnaround cycle after every read burst. The block sits between the VGA timing controller (`video_on`, pixel address) and the external SRAM pins.

## Interface
- `ADDR_W`, 19, SRAM address width (640x480 frame)
- `DATA_W`, 8, pixel/SRAM data width
- `FIFO_DEPTH`, 4, write-buffer entries; power of two, at least 2
- `clk_25mhz`  in  1  pixel clock
- `rst`  in  1  reset, asynchronous, active-high
- `video_on`  in  1  scan-out pixel request, from the timing controller
- `pix_addr`  in  ADDR_W  scan-out address, valid when `video_on` is high
- `pix_data`  out  DATA_W  pixel read from SRAM, registered
- `pix_valid`  out  1  `pix_data` updated this cycle
- `wr_valid`  in  1  writer request
- `wr_ready`  out  1  FIFO can accept a request
- `wr_addr`  in  ADDR_W  write address
- `wr_data`  in  DATA_W  write data
- `fifo_level`  out  $clog2(FIFO_DEPTH)+1  entries currently buffered
- `sram_addr`  out  ADDR_W  SRAM address
- `sram_dq_o`  out  DATA_W  SRAM write data
- `sram_dq_i`  in  DATA_W  SRAM read data
- `sram_dq_oe`  out  1  tristate enable for `sram_dq_o`
- `sram_ce_n`  out  1  chip enable, active low
- `sram_oe_n`  out  1  output enable, active low
- `sram_we_n`  out  1  write enable, active low

## Operation
**Grant.** Each cycle a combinational grant is decoded from the inputs, the FIFO and the state register. The first matching rule wins:
1. `rst` high → IDLE.
2. `video_on` high → READ.
3. State is READ → TURN.
4. FIFO non-empty → WRITE.
5. Otherwise → IDLE.

**State register.** Holds the previous grant. States are IDLE, READ, TURN, WRITE; next state equals the current grant.

**SRAM pins per grant:**
- READ: `sram_addr`=`pix_addr`, `ce_n`=0, `oe_n`=0, `we_n`=1, `dq_oe`=0.
- WRITE: `sram_addr`=FIFO head address, `dq_o`=head data, `dq_oe`=1, `ce_n`=0, `we_n`=0, `oe_n`=1. The head is popped at the clock edge.
- TURN / IDLE: `ce_n`=`oe_n`=`we_n`=1, `dq_oe`=0, `sram_addr`=0, `dq_o`=0.

**Read capture.** On every READ cycle, `sram_dq_i` is registered into `pix_data`. `pix_valid` is set the following cycle and cleared otherwise. `pix_data` holds its value when not valid.

**Write FIFO:**
- `wr_ready` = not full.
- A push occurs when `wr_valid && wr_ready`.
- A push and a pop in the same cycle are both performed; the level is unchanged.
- A push into an empty FIFO is not visible to the grant until the next cycle (no bypass).
- `fifo_level` is registered.

**Writes never split.** A write occupies exactly one cycle. Video preempts only between writes, never within one.

**Reset (asynchronous):**
- state=IDLE, FIFO empty, `fifo_level`=0, `pix_data`=0, `pix_valid`=0.
- Entries still queued when reset asserts are discarded.
- All SRAM strobes are inactive while `rst` is high.

## Timing
- Read latency: `pix_addr` in cycle N → `pix_data`/`pix_valid` in cycle N+1. Throughput is one pixel per cycle for the whole active line.
- Read → write needs one TURN cycle. The first write of a blanking interval issues in the second blanking cycle.
- Write → read needs no gap: `video_on` high immediately preempts.
- Push to earliest SRAM write: 1 cycle, during blanking.
- Drain rate during blanking: one entry per cycle. A full FIFO drains in FIFO_DEPTH cycles plus 1 turnaround cycle.
- Writer backpressure: while `video_on` is high, at most FIFO_DEPTH requests are accepted; then `wr_ready`=0 until blanking.

## Structure
- Grant/state enum `arb_state_t` (IDLE, READ, TURN, WRITE) is added to the shared VGA package.
- A sub-module `sync_fifo` (parameterised width/depth, push/pop/full/empty/level) holds the write buffer. It stores {addr, data} concatenated.
- The arbiter itself contains the state register, grant decode, pin mux and read-capture register.

## Test plan
- **Reset:** assert `rst` mid-burst with 3 entries queued → `fifo_level`=0, `pix_valid`=0, all `sram_*_n`=1, `dq_oe`=0.
- **Scan-out:** `video_on`=1 for 640 cycles with `pix_addr` 0..639 and the SRAM model returning addr[7:0] → `pix_data` follows 0..255,0.. one cycle late, with `pix_valid` high for exactly 640 cycles.
- **Queued write:** push 4 writes (addr 0x100..0x103, data 0xA0..0xA3) while `video_on`=1 → `wr_ready`=0 after the 4th. `video_on` falls at cycle T → TURN at T, writes at T+1..T+4 in order, `wr_ready`=1 from T+2.
- **Preemption:** 2 entries queued, blanking lasts 2 cycles → TURN, one write, then READ. The second entry stays queued (`fifo_level`=1) and writes in the next blanking.
- **Simultaneous events:** push and pop in the same cycle at level 2 → level stays 2, data order preserved.
- **Empty-push:** push at level 0 during idle blanking → WRITE grant appears the next cycle, never the same cycle.

Source files
------------

// File: rtl/vga_sram_arbiter_pkg.sv
// rtl/vga_sram_arbiter_pkg.sv - shared VGA types: arbiter grant enum and SRAM strobe bundle
package vga_sram_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_TURN  = 2'd2,
        ST_WRITE = 2'd3
    } arb_state_t;

    typedef struct packed {
        logic ce_n;
        logic oe_n;
        logic we_n;
        logic dq_oe;
    } sram_ctrl_t;

    localparam sram_ctrl_t CTRL_OFF   = '{ce_n: 1'b1, oe_n: 1'b1, we_n: 1'b1, dq_oe: 1'b0};
    localparam sram_ctrl_t CTRL_READ  = '{ce_n: 1'b0, oe_n: 1'b0, we_n: 1'b1, dq_oe: 1'b0};
    localparam sram_ctrl_t CTRL_WRITE = '{ce_n: 1'b0, oe_n: 1'b1, we_n: 1'b0, dq_oe: 1'b1};

    function automatic sram_ctrl_t ctrl_for_grant(input arb_state_t grant);
        case (grant)
            ST_READ:  return CTRL_READ;
            ST_WRITE: return CTRL_WRITE;
            default:  return CTRL_OFF;
        endcase
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with registered level, no push-to-pop bypass
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_push_data,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_pop_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [LW-1:0]    r_level;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full     = (r_level == LW'(DEPTH));
    assign o_empty    = (r_level == '0);
    assign o_level    = r_level;
    assign o_pop_data = r_mem[r_rd_ptr];

    // Guard here too so a misbehaving client cannot corrupt the pointers.
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    always_ff @(posedge i_clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

endmodule

// File: rtl/vga_sram_arbiter.sv
// rtl/vga_sram_arbiter.sv - shares the pixel SRAM between VGA scan-out reads and buffered writes
module vga_sram_arbiter
    import vga_sram_arbiter_pkg::*;
#(
    parameter int ADDR_W     = 19,
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk_25mhz,
    input  logic                          rst,
    input  logic                          video_on,
    input  logic [ADDR_W-1:0]             pix_addr,
    output logic [DATA_W-1:0]             pix_data,
    output logic                          pix_valid,
    input  logic                          wr_valid,
    output logic                          wr_ready,
    input  logic [ADDR_W-1:0]             wr_addr,
    input  logic [DATA_W-1:0]             wr_data,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic [ADDR_W-1:0]             sram_addr,
    output logic [DATA_W-1:0]             sram_dq_o,
    input  logic [DATA_W-1:0]             sram_dq_i,
    output logic                          sram_dq_oe,
    output logic                          sram_ce_n,
    output logic                          sram_oe_n,
    output logic                          sram_we_n
);

    arb_state_t              r_state;
    arb_state_t              w_grant;
    sram_ctrl_t              w_ctrl;
    logic                    w_fifo_full;
    logic                    w_fifo_empty;
    logic                    w_push;
    logic                    w_pop;
    logic [ADDR_W+DATA_W-1:0] w_head;
    logic [ADDR_W-1:0]       w_head_addr;
    logic [DATA_W-1:0]       w_head_data;
    logic [DATA_W-1:0]       r_pix_data;
    logic                    r_pix_valid;

    assign wr_ready                   = !w_fifo_full;
    assign w_push                     = wr_valid && !w_fifo_full;
    assign w_pop                      = (w_grant == ST_WRITE);
    assign {w_head_addr, w_head_data} = w_head;

    sync_fifo #(
        .WIDTH (ADDR_W + DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_wr_fifo (
        .i_clk       (clk_25mhz),
        .i_rst       (rst),
        .i_push      (w_push),
        .i_push_data ({wr_addr, wr_data}),
        .i_pop       (w_pop),
        .o_pop_data  (w_head),
        .o_full      (w_fifo_full),
        .o_empty     (w_fifo_empty),
        .o_level     (fifo_level)
    );

    always_ff @(posedge clk_25mhz or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_grant;
        end
    end

    // Grant is decoded from the current cycle so scan-out never waits; writes last
    // exactly one cycle, so video can only preempt at a write boundary.
    always_comb begin
        w_grant = ST_IDLE;
        if (rst) begin
            w_grant = ST_IDLE;
        end else if (video_on) begin
            w_grant = ST_READ;
        end else if (r_state == ST_READ) begin
            w_grant = ST_TURN;
        end else if (!w_fifo_empty) begin
            w_grant = ST_WRITE;
        end
    end

    always_comb begin
        w_ctrl    = ctrl_for_grant(w_grant);
        sram_addr = '0;
        sram_dq_o = '0;
        case (w_grant)
            ST_READ: begin
                sram_addr = pix_addr;
            end
            ST_WRITE: begin
                sram_addr = w_head_addr;
                sram_dq_o = w_head_data;
            end
            default: begin
                sram_addr = '0;
                sram_dq_o = '0;
            end
        endcase
        sram_ce_n  = w_ctrl.ce_n;
        sram_oe_n  = w_ctrl.oe_n;
        sram_we_n  = w_ctrl.we_n;
        sram_dq_oe = w_ctrl.dq_oe;
    end

    always_ff @(posedge clk_25mhz or posedge rst) begin
        if (rst) begin
            r_pix_data  <= '0;
            r_pix_valid <= 1'b0;
        end else begin
            r_pix_valid <= (w_grant == ST_READ);
            if (w_grant == ST_READ) begin
                r_pix_data <= sram_dq_i;
            end
        end
    end

    assign pix_data  = r_pix_data;
    assign pix_valid = r_pix_valid;

endmodule
